// File: rtl/i2c_slave_responder_pkg.sv
// Shared types for the I2C target: FSM state encoding, ACK levels and R/W bit meaning.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } i2c_slv_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Status and write-commit bundle of the I2C target, plus its FSM state for observers.
interface i2c_slave_responder_if #(
  parameter int PTR_W = 7
);
  import i2c_pkg::*;

  // wr_strobe is a one-cycle valid with no ready: wr_ptr/wr_data are only
  // meaningful in that cycle and the consumer must take them then.
  logic               busy;
  logic               wr_strobe;
  logic [PTR_W-1:0]   wr_ptr;
  logic [7:0]         wr_data;
  i2c_slv_state_t     state;

  modport slave (
    output busy, wr_strobe, wr_ptr, wr_data, state
  );

  modport master (
    input busy, wr_strobe, wr_ptr, wr_data, state
  );

endinterface

// File: rtl/i2c_slave_responder_bus_sync.sv
// Synchronises scl/sda into clk and detects SCL edges and START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_meta_q;
  logic [1:0] sda_meta_q;
  logic       scl_h_q;
  logic       sda_h_q;
  logic       scl_s;

  // Reset to the idle bus level so leaving reset creates no false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 2'b11;
      sda_meta_q <= 2'b11;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
    end else begin
      scl_meta_q <= {scl_meta_q[0], scl};
      sda_meta_q <= {sda_meta_q[0], sda};
      scl_h_q    <= scl_meta_q[1];
      sda_h_q    <= sda_meta_q[1];
    end
  end

  assign scl_s     = scl_meta_q[1];
  assign sda_s     = sda_meta_q[1];
  assign scl_rise  = scl_s & ~scl_h_q;
  assign scl_fall  = ~scl_s & scl_h_q;
  assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with pointer-addressed byte register file on an open-drain bus.
// Define I2C_SLAVE_AUTOINC_EN to advance the pointer after each written / ACKed read byte.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DEPTH    = 128,
  parameter int         PTR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  i2c_slave_responder_if.slave  status_o
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_slv_state_t   state_q;
  logic [2:0]       cnt_q;
  logic [7:0]       shift_q;
  logic [PTR_W-1:0] ptr_q;
  logic             rw_q;
  logic             slot_q;
  logic             ack_seen_q;
  logic             sda_oe_q;
  logic             busy_q;
  logic             wr_strobe_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [7:0]       wr_data_q;
  logic [7:0]       regs_q [DEPTH];
  logic [7:0]       rx_byte;

  assign rx_byte = {shift_q[6:0], sda_s};

  // sda_oe_q is reset asynchronously, so the bus is released the moment rst rises.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= I2C_RW_WRITE;
      slot_q      <= 1'b0;
      ack_seen_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_ptr_q    <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        state_q    <= S_ADDR;
        cnt_q      <= '0;
        slot_q     <= 1'b0;
        ack_seen_q <= 1'b0;
        sda_oe_q   <= 1'b0;
      end else if (stop_det) begin
        state_q    <= S_IDLE;
        slot_q     <= 1'b0;
        ack_seen_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
          end
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                if (state_q == S_ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q <= S_ADDR_ACK;
                    rw_q    <= rx_byte[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q  <= S_IDLE;
                    sda_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                  end
                end else if (state_q == S_PTR) begin
                  ptr_q   <= rx_byte[PTR_W-1:0];
                  state_q <= S_PTR_ACK;
                end else begin
                  state_q <= S_WDATA_ACK;
                end
              end
            end
          end
          // First falling edge opens the ACK slot, the second one closes it.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!slot_q) begin
                slot_q   <= 1'b1;
                sda_oe_q <= ~I2C_ACK;
              end else begin
                slot_q <= 1'b0;
                cnt_q  <= '0;
                if (state_q == S_ADDR_ACK && rw_q == I2C_RW_READ) begin
                  shift_q  <= regs_q[ptr_q];
                  sda_oe_q <= ~regs_q[ptr_q][7];
                  state_q  <= S_RDATA;
                end else if (state_q == S_ADDR_ACK) begin
                  sda_oe_q <= 1'b0;
                  state_q  <= S_PTR;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= S_WDATA;
                  if (state_q == S_WDATA_ACK) begin
                    regs_q[ptr_q] <= shift_q;
                    wr_strobe_q   <= 1'b1;
                    wr_ptr_q      <= ptr_q;
                    wr_data_q     <= shift_q;
`ifdef I2C_SLAVE_AUTOINC_EN
                    ptr_q <= ptr_q + PTR_W'(1);
`else
                    ptr_q <= ptr_q;
`endif
                  end
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) state_q <= S_RDATA_ACK;
            end else if (scl_fall) begin
              sda_oe_q <= ~shift_q[6];
              shift_q  <= {shift_q[6:0], 1'b0};
            end
          end
          S_RDATA_ACK: begin
            if (scl_fall && !slot_q) begin
              slot_q   <= 1'b1;
              sda_oe_q <= 1'b0;
            end else if (scl_rise && slot_q && !ack_seen_q) begin
              if (sda_s == I2C_NACK) begin
                state_q <= S_IDLE;
                slot_q  <= 1'b0;
                busy_q  <= 1'b0;
              end else begin
                ack_seen_q <= 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
                ptr_q <= ptr_q + PTR_W'(1);
`else
                ptr_q <= ptr_q;
`endif
              end
            end else if (scl_fall && ack_seen_q) begin
              slot_q     <= 1'b0;
              ack_seen_q <= 1'b0;
              cnt_q      <= '0;
              shift_q    <= regs_q[ptr_q];
              sda_oe_q   <= ~regs_q[ptr_q][7];
              state_q    <= S_RDATA;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign status_o.busy      = busy_q;
  assign status_o.wr_strobe = wr_strobe_q;
  assign status_o.wr_ptr    = wr_ptr_q;
  assign status_o.wr_data   = wr_data_q;
  assign status_o.state     = state_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged initiator drives scl/sda against the target.
module tb_i2c_slave_responder;
  import i2c_pkg::*;

  localparam int PTR_W = 7;
  localparam int H     = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_responder_if #(.PTR_W(PTR_W)) st_if ();

  i2c_slave_responder #(
    .DEV_ADDR (7'h50),
    .DEPTH    (128),
    .PTR_W    (PTR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .status_o (st_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: run did not finish");
    $fatal(1);
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  logic dut_drove = 1'b0;
  logic [14:0] exp_q[$];
  logic [14:0] exp_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (st_if.wr_strobe === 1'b1) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("strobe_ptr_data", 32'({st_if.wr_ptr, st_if.wr_data}), 32'(exp_e));
      end
    end
    if (sda === 1'b0 && !m_sda_low) dut_drove = 1'b1;
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b1; wait_clk(H);
    scl = 1'b0;       wait_clk(H/2);
  endtask

  task automatic i2c_rstart();
    m_sda_low = 1'b0; wait_clk(H/2);
    scl = 1'b1;       wait_clk(H);
    m_sda_low = 1'b1; wait_clk(H);
    scl = 1'b0;       wait_clk(H/2);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(H/2);
    scl = 1'b1;       wait_clk(H);
    m_sda_low = 1'b0; wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; wait_clk(H/2);
    scl = 1'b1;     wait_clk(H);
    scl = 1'b0;     wait_clk(H/2);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; wait_clk(H/2);
    scl = 1'b1;       wait_clk(H/2);
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_clk(H/2);
    scl = 1'b0;       wait_clk(H/2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic read_reg(input string tag, input logic [7:0] ptr, input logic [7:0] exp);
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(ptr, ack);
    i2c_rstart();
    write_byte(8'hA1, ack);
    read_byte(d, 1'b1);
    i2c_stop();
    chk(tag, 32'(d), 32'(exp));
  endtask

  logic ack;
  logic [7:0] d0, d1;
  logic b;

  initial begin
    wait_clk(5);
    chk("rst_busy",    32'(st_if.busy),      32'd0);
    chk("rst_strobe",  32'(st_if.wr_strobe), 32'd0);
    chk("rst_wr_ptr",  32'(st_if.wr_ptr),    32'd0);
    chk("rst_wr_data", 32'(st_if.wr_data),   32'd0);
    chk("rst_state",   32'(st_if.state),     32'(S_IDLE));
    chk("rst_sda",     32'(sda),             32'd1);
    rst = 1'b0;
    wait_clk(5);

    // single write 0x40 <= 0xA5
    i2c_start();
    write_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 32'd0);
    chk("wr_busy", 32'(st_if.busy), 32'd1);
    write_byte(8'h40, ack); chk("wr_ptr_ack", 32'(ack), 32'd0);
    exp_q.push_back({7'h40, 8'hA5});
    write_byte(8'hA5, ack); chk("wr_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    wait_clk(5);
    chk("wr_busy_after_stop", 32'(st_if.busy), 32'd0);
    chk("wr_strobe_cnt", 32'(strobe_cnt), 32'd1);

    // pointer write, repeated START, read with NACK
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    i2c_rstart();
    write_byte(8'hA1, ack); chk("rd_addr_ack", 32'(ack), 32'd0);
    read_byte(d0, 1'b1);
    chk("rd_data", 32'(d0), 32'hA5);
    chk("rd_busy_after_nack", 32'(st_if.busy), 32'd0);
    chk("rd_sda_released", 32'(sda), 32'd1);
    i2c_stop();

    // wrong device address
    dut_drove = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); chk("bad_addr_nack", 32'(ack), 32'd1);
    write_byte(8'h40, ack); chk("bad_addr_ignored", 32'(ack), 32'd1);
    i2c_stop();
    wait_clk(5);
    chk("bad_addr_no_drive", 32'(dut_drove), 32'd0);
    chk("bad_addr_busy", 32'(st_if.busy), 32'd0);
    chk("bad_addr_strobe_cnt", 32'(strobe_cnt), 32'd1);

    // burst write across the pointer wrap
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h7F, ack);
    exp_q.push_back({7'h7F, 8'h11});
`ifdef I2C_SLAVE_AUTOINC_EN
    exp_q.push_back({7'h00, 8'h22});
`else
    exp_q.push_back({7'h7F, 8'h22});
`endif
    write_byte(8'h11, ack); chk("burst_ack0", 32'(ack), 32'd0);
    write_byte(8'h22, ack); chk("burst_ack1", 32'(ack), 32'd0);
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h7F, ack);
    i2c_rstart();
    write_byte(8'hA1, ack);
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    i2c_stop();
`ifdef I2C_SLAVE_AUTOINC_EN
    chk("burst_rd0", 32'(d0), 32'h11);
`else
    chk("burst_rd0", 32'(d0), 32'h22);
`endif
    chk("burst_rd1", 32'(d1), 32'h22);
    chk("burst_strobe_cnt", 32'(strobe_cnt), 32'd3);

    // STOP after 5 data bits
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    for (int i = 0; i < 5; i++) write_bit(1'b1);
    i2c_stop();
    wait_clk(5);
    chk("midstop_state", 32'(st_if.state), 32'(S_IDLE));
    chk("midstop_busy", 32'(st_if.busy), 32'd0);
    chk("midstop_strobe_cnt", 32'(strobe_cnt), 32'd3);
    read_reg("midstop_reg_kept", 8'h40, 8'hA5);

    // reset during the 4th data bit of a read (0xA5: 4th bit is 0)
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    i2c_rstart();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) read_bit(b);
    wait_clk(1);
    chk("rstmid_sda_driven", 32'(sda), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_sda_released", 32'(sda), 32'd1);
    chk("rstmid_busy", 32'(st_if.busy), 32'd0);
    chk("rstmid_state", 32'(st_if.state), 32'(S_IDLE));
    wait_clk(2);
    rst = 1'b0;
    wait_clk(3);
    i2c_stop();
    read_reg("rstmid_reg_cleared", 8'h40, 8'h00);

    i2c_start();
    write_byte(8'hA0, ack); chk("post_rst_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h10, ack);
    exp_q.push_back({7'h10, 8'h3C});
    write_byte(8'h3C, ack); chk("post_rst_data_ack", 32'(ack), 32'd0);
    i2c_stop();
    read_reg("post_rst_readback", 8'h10, 8'h3C);

    wait_clk(5);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("final_strobe_cnt", 32'(strobe_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
